// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: XLEN shift-add or restoring shift-subtract
// steps, then a sign-fix cycle. Holds the pipeline through stall until done pulses.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   acc_q, acc_d;   // product upper half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // product lower half / quotient
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sgn_a, sgn_b, na, nb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, r_sh;
  logic [XLEN-1:0]   q_sh, quo, rem, fix_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    is_div = Funct3[2];
    sgn_a  = is_div ? ~Funct3[0] : (Funct3 == 3'b001 || Funct3 == 3'b010);
    sgn_b  = is_div ? ~Funct3[0] : (Funct3 == 3'b001);
    na     = sgn_a & rs1[XLEN-1];
    nb     = sgn_b & rs2[XLEN-1];
    mag_a  = na ? -rs1 : rs1;
    mag_b  = nb ? -rs2 : rs2;

    // Multiply step: conditional add into upper half, then shift the whole product right.
    sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide step: shift {R,Q} left; remainder never exceeds XLEN bits after restore.
    r_sh = {acc_q, lo_q[XLEN-1]};
    q_sh = {lo_q[XLEN-2:0], 1'b0};

    prod = {acc_q, lo_q};
    if (neg_a_q ^ neg_b_q) prod = -prod;
    quo  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem  = neg_a_q ? -acc_q : acc_q;
    if (f3_q[2])             fix_res = f3_q[1] ? rem : quo;
    else if (f3_q == 3'b000) fix_res = prod[XLEN-1:0];
    else                     fix_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_d      = b_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready    = (state_q == IDLE);
    done     = (state_q == DONE);
    stall    = (start && ready) || state_q == BUSY || state_q == FIX;

    case (state_q)
      IDLE: if (start && !flush) begin
        f3_d    = Funct3;
        neg_a_d = na;
        neg_b_d = nb;
        b_d     = mag_b;
        acc_d   = '0;
        lo_d    = mag_a;
        cnt_d   = '0;
        if (is_div && rs2 == '0) begin
          result_d = Funct3[1] ? rs1 : '1;
          state_d  = DONE;
        end else if (is_div && !Funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
          result_d = Funct3[1] ? '0 : rs1;
          state_d  = DONE;
        end else begin
          state_d  = BUSY;
        end
      end
      BUSY: if (flush) begin
        state_d = IDLE;
      end else begin
        if (f3_q[2]) begin
          if (r_sh >= {1'b0, b_q}) begin
            acc_d = XLEN'(r_sh - {1'b0, b_q});
            lo_d  = q_sh | 1'b1;
          end else begin
            acc_d = r_sh[XLEN-1:0];
            lo_d  = q_sh;
          end
        end else begin
          acc_d = sum[XLEN:1];
          lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      end
      FIX: if (flush) begin
        state_d = IDLE;
      end else begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
endmodule
